// File: rtl/dpd_pkg.sv
// Shared constants and FSM encoding for the GAN-DPD feature path.
package dpd_pkg;

    localparam int unsigned DATA_WIDTH   = 16;
    localparam int unsigned MEMORY_DEPTH = 5;
    localparam int unsigned OUTPUT_DIM   = 2 + 3 * (MEMORY_DEPTH + 1) + 2 * MEMORY_DEPTH;
    localparam int unsigned INDEX_WIDTH  = $clog2(OUTPUT_DIM);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } fsm_state_t;

endpackage

// File: rtl/vector_slot_reg.sv
// Wide vector holding register with a full flag; load takes priority over clear.
module vector_slot_reg
    import dpd_pkg::*;
#(
    parameter int unsigned WIDTH = dpd_pkg::DATA_WIDTH * dpd_pkg::OUTPUT_DIM
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full
);

    // Capture a vector on load; clear only drops the full flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
            full <= 1'b0;
        end else if (load) begin
            dout <= din;
            full <= 1'b1;
        end else if (clear) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/feature_vector_serializer.sv
// Captures a flat feature vector on a valid pulse and streams it out one
// element per beat. One active and one pending slot absorb back-to-back
// pulses; further pulses are dropped and flagged on overflow.
// Optional macro FEATSER_DROP_CNT_EN adds an 8-bit saturating drop counter.
module feature_vector_serializer
    import dpd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = dpd_pkg::DATA_WIDTH,
    parameter int unsigned VEC_DIM    = dpd_pkg::OUTPUT_DIM,
    parameter int unsigned IDX_W      = dpd_pkg::INDEX_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_WIDTH*VEC_DIM-1:0] in_vector,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [IDX_W-1:0]              out_index,
    output logic                          out_last,
    output logic                          out_valid,
    input  logic                          out_ready,
`ifdef FEATSER_DROP_CNT_EN
    output logic [7:0]                    drop_cnt,
`endif
    output logic                          overflow
);

    localparam int unsigned      VEC_W    = DATA_WIDTH * VEC_DIM;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_DIM - 1);

    fsm_state_t state, state_next;

    logic [VEC_W-1:0]      act_data, pend_data, act_din, mux_src;
    logic                  act_full, pend_full;
    logic                  act_load, act_clear, pend_load, pend_clear;
    logic [IDX_W-1:0]      index_next;
    logic [DATA_WIDTH-1:0] elem;
    logic                  drop;
    logic                  beat, last_beat;

    assign beat      = out_valid && out_ready;
    assign last_beat = beat && out_last;
    assign out_valid = act_full;
    assign in_ready  = !pend_full;

    vector_slot_reg #(.WIDTH(VEC_W)) u_active (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (act_load),
        .clear (act_clear),
        .din   (act_din),
        .dout  (act_data),
        .full  (act_full)
    );

    vector_slot_reg #(.WIDTH(VEC_W)) u_pending (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (pend_load),
        .clear (pend_clear),
        .din   (in_vector),
        .dout  (pend_data),
        .full  (pend_full)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, slot control and next element index.
    // mux_src names the vector that will be active next cycle, so the
    // element register can be loaded straight from an incoming or pending
    // vector on handover without a bubble.
    always_comb begin
        state_next = state;
        act_load   = 1'b0;
        act_clear  = 1'b0;
        pend_load  = 1'b0;
        pend_clear = 1'b0;
        act_din    = in_vector;
        mux_src    = act_data;
        index_next = out_index;
        drop       = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    act_load   = 1'b1;
                    mux_src    = in_vector;
                    index_next = '0;
                    state_next = STREAM;
                end
            end
            STREAM: begin
                if (last_beat) begin
                    index_next = '0;
                    if (pend_full) begin
                        act_load   = 1'b1;
                        act_din    = pend_data;
                        mux_src    = pend_data;
                        pend_load  = in_valid;
                        pend_clear = !in_valid;
                    end else if (in_valid) begin
                        act_load = 1'b1;
                        mux_src  = in_vector;
                    end else begin
                        act_clear  = 1'b1;
                        state_next = IDLE;
                    end
                end else begin
                    if (beat) begin
                        index_next = out_index + IDX_W'(1);
                    end
                    if (in_valid) begin
                        if (pend_full) begin
                            drop = 1'b1;
                        end else begin
                            pend_load = 1'b1;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Element select from the next-active vector at the next index.
    always_comb begin
        elem = '0;
        for (int unsigned k = 0; k < VEC_DIM; k++) begin
            if (index_next == IDX_W'(k)) begin
                elem = mux_src[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Registered stream outputs; zeroed while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
        end else if (state_next == STREAM) begin
            out_data  <= elem;
            out_index <= index_next;
            out_last  <= (index_next == LAST_IDX);
        end else begin
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
        end
    end

    // Sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end

`ifdef FEATSER_DROP_CNT_EN
    // Saturating count of dropped vectors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_feature_vector_serializer.sv
// Directed self-checking bench for feature_vector_serializer.
// Drop-counter checks are built when FEATSER_DROP_CNT_EN is defined.
module tb_feature_vector_serializer;

    localparam int unsigned DW  = 16;
    localparam int unsigned VD  = 30;
    localparam int unsigned IW  = 5;

    logic              clk;
    logic              rst_n;
    logic [DW*VD-1:0]  in_vector;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     out_data;
    logic [IW-1:0]     out_index;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;
    logic              overflow;
`ifdef FEATSER_DROP_CNT_EN
    logic [7:0]        drop_cnt;
`endif

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    feature_vector_serializer #(
        .DATA_WIDTH (DW),
        .VEC_DIM    (VD),
        .IDX_W      (IW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_vector (in_vector),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef FEATSER_DROP_CNT_EN
        .drop_cnt  (drop_cnt),
`endif
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW*VD-1:0] make_vec(input logic [15:0] base);
        logic [DW*VD-1:0] v;
        v = '0;
        for (int k = 0; k < int'(VD); k++) begin
            v[k*DW +: DW] = base + 16'(k);
        end
        return v;
    endfunction

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Consume a full vector at full rate, checking every beat.
    task automatic expect_vector(input string tag, input logic [15:0] base);
        for (int k = 0; k < int'(VD); k++) begin
            out_ready = 1'b1;
            check({tag, "_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_index"}, 32'(out_index), 32'(k));
            check({tag, "_data"},  32'(out_data), 32'(base + 16'(k)));
            check({tag, "_last"},  32'(out_last), 32'(k == int'(VD) - 1));
            tick();
        end
    endtask

    initial begin
        int got;
        rst_n     = 1'b0;
        in_vector = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #23;
        check("rst_valid",    32'(out_valid), 32'd0);
        check("rst_data",     32'(out_data),  32'd0);
        check("rst_index",    32'(out_index), 32'd0);
        check("rst_last",     32'(out_last),  32'd0);
        check("rst_in_ready", 32'(in_ready),  32'd1);
        check("rst_overflow", 32'(overflow),  32'd0);
`ifdef FEATSER_DROP_CNT_EN
        check("rst_drop_cnt", 32'(drop_cnt),  32'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Basic stream
        in_vector = make_vec(16'h0100);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        expect_vector("basic", 16'h0100);
        check("basic_idle", 32'(out_valid), 32'd0);

        // Backpressure with out_ready 1,0,0,...
        in_vector = make_vec(16'h0400);
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        got = 0;
        for (int c = 0; c < 200 && got < int'(VD); c++) begin
            out_ready = (c % 3 == 0);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_index", 32'(out_index), 32'(got));
            check("bp_data",  32'(out_data),  32'(16'h0400 + 16'(got)));
            tick();
            if (out_ready) got++;
        end
        check("bp_count", 32'(got), 32'(VD));
        out_ready = 1'b1;
        check("bp_idle", 32'(out_valid), 32'd0);

        // Back-to-back: B pulse three cycles after A
        in_vector = make_vec(16'h0100);
        in_valid  = 1'b1;
        tick();
        for (int n = 0; n < 2 * int'(VD); n++) begin
            in_valid = (n == 3);
            if (n == 3) in_vector = make_vec(16'h0200);
            check("b2b_valid", 32'(out_valid), 32'd1);
            check("b2b_index", 32'(out_index), 32'(n % int'(VD)));
            check("b2b_data",  32'(out_data),
                  32'(((n < int'(VD)) ? 16'h0100 : 16'h0200) + 16'(n % int'(VD))));
            if (n == 4 || n == int'(VD) - 1) check("b2b_in_ready_low", 32'(in_ready), 32'd0);
            if (n == int'(VD)) check("b2b_in_ready_back", 32'(in_ready), 32'd1);
            tick();
        end
        in_valid = 1'b0;
        check("b2b_idle", 32'(out_valid), 32'd0);

        // Simultaneous pulse on A's last beat, pending empty
        do_reset();
        in_vector = make_vec(16'h0100);
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int n = 0; n < int'(VD) - 1; n++) tick();
        check("sim_last_index", 32'(out_index), 32'(VD - 1));
        in_vector = make_vec(16'h0300);
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        check("sim_overflow", 32'(overflow), 32'd0);
        expect_vector("sim", 16'h0300);
        check("sim_idle", 32'(out_valid), 32'd0);

        // Reset mid-stream at index 12
        in_vector = make_vec(16'h0100);
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int n = 0; n < 12; n++) tick();
        check("rmid_index_before", 32'(out_index), 32'd12);
        rst_n = 1'b0;
        #1;
        check("rmid_valid",    32'(out_valid), 32'd0);
        check("rmid_index",    32'(out_index), 32'd0);
        check("rmid_in_ready", 32'(in_ready),  32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("rmid_still_idle", 32'(out_valid), 32'd0);
        in_vector = make_vec(16'h0200);
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        expect_vector("rmid", 16'h0200);
        check("rmid_idle", 32'(out_valid), 32'd0);

        // Overflow: A, B, C while stalled
        do_reset();
        out_ready = 1'b0;
        in_vector = make_vec(16'h0100);
        in_valid  = 1'b1;
        tick();
        in_vector = make_vec(16'h0200);
        tick();
        in_vector = make_vec(16'h0300);
        tick();
        in_valid = 1'b0;
        tick();
        check("ovf_flag",     32'(overflow),  32'd1);
        check("ovf_in_ready", 32'(in_ready),  32'd0);
        check("ovf_index",    32'(out_index), 32'd0);
        check("ovf_data",     32'(out_data),  32'h0100);
`ifdef FEATSER_DROP_CNT_EN
        check("ovf_drop_cnt_1", 32'(drop_cnt), 32'd1);
        for (int n = 0; n < 300; n++) begin
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            tick();
        end
        check("ovf_drop_cnt_sat", 32'(drop_cnt), 32'd255);
`endif
        expect_vector("ovf_a", 16'h0100);
        expect_vector("ovf_b", 16'h0200);
        check("ovf_idle",   32'(out_valid), 32'd0);
        check("ovf_sticky", 32'(overflow),  32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/feature_vector_serializer.md
Name: feature_vector_serializer

Overview:
- Consumer end of the memory-tap feature vector interface.
- Captures the wide, flat vector presented with a one-cycle valid pulse and streams it out one DATA_WIDTH element per beat over a valid/ready stream to the GAN-DPD MAC array.
- Holds one active and one pending vector so back-to-back producer pulses survive backpressure; anything beyond that is dropped and flagged.

Parameters:
- DATA_WIDTH, 16: element width, Q1.15.
- VEC_DIM, 30: elements per vector, 2 + 3*(M+1) + 2*M for M = 5.
- IDX_W, 5: index width, must satisfy 2^IDX_W >= VEC_DIM.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_vector  in  DATA_WIDTH*VEC_DIM  flat vector; element k occupies [DATA_WIDTH*(k+1)-1 : DATA_WIDTH*k].
- in_valid  in  1  capture strobe; the producer does not honour ready.
- in_ready  out  1  high while the pending slot is empty (advisory only).
- out_data  out  DATA_WIDTH  current element.
- out_index  out  IDX_W  element index, 0..VEC_DIM-1.
- out_last  out  1  high with index VEC_DIM-1.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready; a beat transfers when out_valid && out_ready.
- overflow  out  1  sticky; set on any dropped vector, cleared only by reset.

Behaviour:
- Clock and reset: one clock (clk); asynchronous active-low reset (rst_n).
- Reset values: out_valid=0, out_data=0, out_index=0, out_last=0, in_ready=1, overflow=0. Both slots are marked empty. Reset asserted mid-stream abandons the vector at once, and no further beats are emitted.
- FSM states:
  - IDLE: active slot empty.
  - STREAM: active slot holds a vector and is being emitted.
- Capture in IDLE: in_valid=1 in cycle t loads the active slot. In cycle t+1: out_valid=1, out_index=0, out_data = element 0. Latency is 1 cycle.
- Capture in STREAM: in_valid with pending empty loads the pending slot and drops in_ready the next cycle. in_valid with pending full drops the new vector and sets overflow. Both existing slots are left untouched.
- Stream rules:
  - out_data, out_index and out_last are held stable while out_valid && !out_ready.
  - Each accepted beat increments out_index.
  - out_last = (out_index == VEC_DIM-1).
- Last beat accepted, pending full: pending moves to active. Next cycle out_valid stays 1 with index 0, so there is no bubble. Pending becomes empty and in_ready returns to 1.
- Last beat accepted, pending empty, no in_valid: go to IDLE with out_valid=0.
- Simultaneous events on the last-beat cycle:
  - in_valid with pending empty: the new vector goes straight into active and streams index 0 next cycle, with no bubble.
  - in_valid with pending full: pending moves to active and the new vector goes to pending. No drop, no overflow.
- Sustained throughput: one element per cycle with out_ready=1; one vector per VEC_DIM cycles.
- Element mux: out_data is registered from the active slot selected by the next index. No combinational path from in_vector to out_data.
- No arithmetic is performed on data; elements pass through bit-exact.

Optional Feature:
- Macro: FEATSER_DROP_CNT_EN.
- Defined: adds output port drop_cnt [7:0], an 8-bit saturating count of dropped vectors. It resets to 0, increments once per dropped in_valid pulse, and holds at 255.
- Undefined: the port and its counter are absent; overflow alone reports drops.
- All other behaviour is identical with or without the macro.

Decomposition:
- Shared package dpd_pkg holds DATA_WIDTH, MEMORY_DEPTH, OUTPUT_DIM (= VEC_DIM), an index-width constant, and the FSM state encoding (IDLE=0, STREAM=1).
- One natural sub-module, vector_slot_reg: a wide register with load, clear and a full flag, instantiated twice (active and pending).
- The FSM, counter and output mux stay in the top module.

Test Plan:
- Basic stream: element k = 16'h0100+k, single in_valid pulse, out_ready=1. Expect out_valid from t+1 for 30 cycles; out_data 0x0100..0x011D; index 0..29; out_last only on the 30th beat; then out_valid=0.
- Backpressure: out_ready toggled 1,0,0,1,... Expect out_data/out_index held through every stall; all 30 elements delivered in order exactly once.
- Back-to-back: vector A pulse, then vector B pulse 3 cycles later, out_ready=1. Expect in_ready=0 from B+1; A's last beat immediately followed by B index 0 with no idle cycle; in_ready=1 after the handover.
- Overflow: pulses for A, B, C within 5 cycles, out_ready=0. Expect C dropped, overflow=1, A then B streamed intact. With FEATSER_DROP_CNT_EN, drop_cnt=1; after 300 further drops it holds at 255.
- Simultaneous: in_valid coincident with A's last-beat acceptance, pending empty. Expect the new vector's index 0 on the next cycle and overflow still 0.
- Reset mid-stream: assert rst_n=0 at A's index 12. Expect out_valid=0, out_index=0 and in_ready=1 immediately. After release, a fresh pulse streams from index 0.
